// File: rtl/rf_arb_pkg.sv
// Shared constants and types for the register-file write arbiter.
//   DATA_W / ADDR_W : register data and address widths
//   DEPTH           : MC result FIFO entries (power of 2, >= 2)
//   STARVE_MAX      : consecutive lost cycles before the FIFO head is forced in
//   rf_wr_t         : one register write {addr, data}
//   src_e           : which requester owns the write port this cycle
package rf_arb_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned ADDR_W     = 5;
  localparam int unsigned DEPTH      = 4;
  localparam int unsigned STARVE_MAX = 3;

  localparam int unsigned PTR_W    = $clog2(DEPTH);
  localparam int unsigned CNT_W    = $clog2(DEPTH) + 1;
  localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } rf_wr_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_WB   = 2'd1,
    SRC_MC   = 2'd2
  } src_e;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Bundle of WB, MC, hazard-lookup and register-file write signals.
//   master : pipeline side (drives requests and read addresses)
//   slave  : arbiter side (drives stall, ready, pending hits, rf write)
interface rf_write_arbiter_if;
  import rf_arb_pkg::*;

  logic              wb_we;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              wb_stall;
  logic              mc_valid;
  logic              mc_ready;
  logic [ADDR_W-1:0] mc_addr;
  logic [DATA_W-1:0] mc_data;
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic              pend_hit1;
  logic              pend_hit2;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_wdata;

  modport master (
    output wb_we, wb_addr, wb_data, mc_valid, mc_addr, mc_data, rd_addr1, rd_addr2,
    input  wb_stall, mc_ready, pend_hit1, pend_hit2, rf_we, rf_addr, rf_wdata
  );

  modport slave (
    input  wb_we, wb_addr, wb_data, mc_valid, mc_addr, mc_data, rd_addr1, rd_addr2,
    output wb_stall, mc_ready, pend_hit1, pend_hit2, rf_we, rf_addr, rf_wdata
  );

endinterface

// File: rtl/rf_wr_fifo.sv
// Small circular FIFO of pending MC register writes.
//   clk, reset   : clock, synchronous active-low reset (empties the FIFO)
//   push_i/wr_i  : enqueue wr_i (ignored when full, even if popping)
//   pop_i        : dequeue head (ignored when empty)
//   head_o       : oldest entry
//   full_o       : no free entry
//   count_o      : number of valid entries
//   entry_addr_o : address field of every slot
//   entry_vld_o  : per-slot valid bit
module rf_wr_fifo
  import rf_arb_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push_i,
  input  rf_wr_t                        wr_i,
  input  logic                          pop_i,
  output rf_wr_t                        head_o,
  output logic                          full_o,
  output logic [CNT_W-1:0]              count_o,
  output logic [DEPTH-1:0][ADDR_W-1:0]  entry_addr_o,
  output logic [DEPTH-1:0]              entry_vld_o
);

  rf_wr_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [DEPTH-1:0] vld_q, vld_d;
  logic             push_ok;
  logic             pop_ok;

  // Full blocks a push regardless of a same-cycle pop (no pass-through).
  always_comb begin
    push_ok  = push_i && (count_q != CNT_W'(DEPTH));
    pop_ok   = pop_i && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    vld_d    = vld_q;
    if (pop_ok) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + PTR_W'(1);
    end
    if (push_ok) begin
      vld_d[wr_ptr_q] = 1'b1;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end

  // Control state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      vld_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      vld_q    <= vld_d;
    end
  end

  // Payload storage; contents are qualified by vld_q so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_i;
  end

  always_comb begin
    head_o      = mem_q[rd_ptr_q];
    full_o      = (count_q == CNT_W'(DEPTH));
    count_o     = count_q;
    entry_vld_o = vld_q;
    for (int unsigned i = 0; i < DEPTH; i++) entry_addr_o[i] = mem_q[i].addr;
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between WB and a multi-cycle unit.
//   clk   : rising-edge clock
//   reset : synchronous active-low reset; discards all queued MC results
//   bus   : slave side of rf_write_arbiter_if (WB request/stall, MC valid/ready,
//           hazard lookup addresses and pending hits, rf write port)
module rf_write_arbiter
  import rf_arb_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  rf_write_arbiter_if.slave   bus
);

  rf_wr_t                       head;
  logic                         fifo_full;
  logic [CNT_W-1:0]             fifo_count;
  logic [DEPTH-1:0][ADDR_W-1:0] entry_addr;
  logic [DEPTH-1:0]             entry_vld;
  logic                         push;
  logic                         head_present;
  logic                         collide;
  logic                         starved;
  src_e                         win_src;
  rf_wr_t                       win_wr;
  logic [STARVE_W-1:0]          starve_q, starve_d;

  rf_wr_fifo u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push_i       (push),
    .wr_i         ('{addr: bus.mc_addr, data: bus.mc_data}),
    .pop_i        (win_src == SRC_MC),
    .head_o       (head),
    .full_o       (fifo_full),
    .count_o      (fifo_count),
    .entry_addr_o (entry_addr),
    .entry_vld_o  (entry_vld)
  );

  // Winner selection; an address match with the head lets the older MC value land first.
  always_comb begin
    head_present = reset && (fifo_count != '0);
    collide      = bus.wb_we && (bus.wb_addr == head.addr) && (head.addr != '0);
    starved      = (starve_q == STARVE_W'(STARVE_MAX));
    win_src      = SRC_NONE;
    if (head_present && (!bus.wb_we || starved || collide)) win_src = SRC_MC;
    else if (reset && bus.wb_we)                            win_src = SRC_WB;
  end

  // Write port, handshakes and stall. Address 0 is consumed without a write.
  always_comb begin
    win_wr = '0;
    case (win_src)
      SRC_MC:  win_wr = head;
      SRC_WB:  win_wr = '{addr: bus.wb_addr, data: bus.wb_data};
      default: win_wr = '0;
    endcase
    bus.rf_we    = (win_src != SRC_NONE) && (win_wr.addr != '0);
    bus.rf_addr  = win_wr.addr;
    bus.rf_wdata = win_wr.data;
    bus.wb_stall = reset && bus.wb_we && (win_src == SRC_MC);
    bus.mc_ready = reset && !fifo_full;
    push         = bus.mc_valid && bus.mc_ready;
  end

  // Pending-write lookup over every valid entry, including one popping this cycle.
  always_comb begin
    bus.pend_hit1 = 1'b0;
    bus.pend_hit2 = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (entry_vld[i] && (entry_addr[i] == bus.rd_addr1)) bus.pend_hit1 = 1'b1;
      if (entry_vld[i] && (entry_addr[i] == bus.rd_addr2)) bus.pend_hit2 = 1'b1;
    end
    bus.pend_hit1 = bus.pend_hit1 && reset && (bus.rd_addr1 != '0);
    bus.pend_hit2 = bus.pend_hit2 && reset && (bus.rd_addr2 != '0);
  end

  // Starve counter: counts cycles the present head loses to WB, saturating.
  always_comb begin
    starve_d = starve_q;
    if (!head_present || (win_src == SRC_MC)) starve_d = '0;
    else if (!starved)                        starve_d = starve_q + STARVE_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) starve_q <= '0;
    else        starve_q <= starve_d;
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: a queue-based reference model predicts
// per-cycle status and the ordered stream of register writes; a negedge monitor
// compares the DUT against both.
module tb_rf_write_arbiter;
  import rf_arb_pkg::*;

  typedef struct {
    bit we;
    bit stall;
    bit ready;
    bit hit1;
    bit hit2;
  } status_t;

  logic clk = 1'b0;
  logic reset;
  rf_write_arbiter_if bus ();

  rf_write_arbiter u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model state.
  rf_wr_t            mq [$];
  int                starve = 0;
  bit                hold_wb = 0;
  logic [ADDR_W-1:0] held_a;
  logic [DATA_W-1:0] held_d;

  // Scoreboard queues.
  status_t sq [$];
  rf_wr_t  wq [$];
  int      tests = 0;
  int      fails = 0;
  int      cyc = 0;

  // One clock of stimulus; the model produces this cycle's expectations.
  task automatic step(input bit rst_v,
                      input bit we, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                      input bit mv, input logic [ADDR_W-1:0] ma, input logic [DATA_W-1:0] md,
                      input logic [ADDR_W-1:0] r1, input logic [ADDR_W-1:0] r2);
    status_t e;
    rf_wr_t  h;
    rf_wr_t  w;
    bit      head, mc_wins, wb_wins, do_push;
    @(posedge clk);
    #1;
    if (rst_v && hold_wb) begin
      we = 1'b1;
      wa = held_a;
      wd = held_d;
    end
    reset        = rst_v;
    bus.wb_we    = we;
    bus.wb_addr  = wa;
    bus.wb_data  = wd;
    bus.mc_valid = mv;
    bus.mc_addr  = ma;
    bus.mc_data  = md;
    bus.rd_addr1 = r1;
    bus.rd_addr2 = r2;
    e = '{default: 0};
    if (!rst_v) begin
      mq.delete();
      starve  = 0;
      hold_wb = 0;
    end else begin
      e.ready = (mq.size() < DEPTH);
      foreach (mq[i]) begin
        if (mq[i].addr == r1 && r1 != 0) e.hit1 = 1;
        if (mq[i].addr == r2 && r2 != 0) e.hit2 = 1;
      end
      head = (mq.size() > 0);
      h = head ? mq[0] : '0;
      mc_wins = head && (!we || starve == STARVE_MAX || (wa == h.addr && h.addr != 0));
      wb_wins = we && !mc_wins;
      w = mc_wins ? h : '{addr: wa, data: wd};
      e.stall = mc_wins && we;
      if ((mc_wins || wb_wins) && w.addr != 0) begin
        e.we = 1;
        wq.push_back(w);
      end
      if (!head || mc_wins) starve = 0;
      else if (starve < STARVE_MAX) starve++;
      do_push = mv && e.ready;
      if (mc_wins) void'(mq.pop_front());
      if (do_push) mq.push_back('{addr: ma, data: md});
      hold_wb = e.stall;
      held_a  = wa;
      held_d  = wd;
    end
    sq.push_back(e);
  endtask

  // Monitor: per-cycle status, plus the write stream whenever rf_we is seen.
  always @(negedge clk) begin
    status_t e;
    rf_wr_t  w;
    if (sq.size() > 0) begin
      e = sq.pop_front();
      cyc++;
      tests++;
      if (bus.rf_we !== e.we || bus.wb_stall !== e.stall || bus.mc_ready !== e.ready ||
          bus.pend_hit1 !== e.hit1 || bus.pend_hit2 !== e.hit2) begin
        fails++;
        $display("FAIL status cyc%0d: got we=%b stall=%b ready=%b hit1=%b hit2=%b, exp we=%b stall=%b ready=%b hit1=%b hit2=%b",
                 cyc, bus.rf_we, bus.wb_stall, bus.mc_ready, bus.pend_hit1, bus.pend_hit2,
                 e.we, e.stall, e.ready, e.hit1, e.hit2);
      end
      if (bus.rf_we === 1'b1) begin
        tests++;
        if (wq.size() == 0) begin
          fails++;
          $display("FAIL write cyc%0d: got addr=%0d data=%h, exp no write", cyc, bus.rf_addr, bus.rf_wdata);
        end else begin
          w = wq.pop_front();
          if (bus.rf_addr !== w.addr || bus.rf_wdata !== w.data) begin
            fails++;
            $display("FAIL write cyc%0d: got addr=%0d data=%h, exp addr=%0d data=%h",
                     cyc, bus.rf_addr, bus.rf_wdata, w.addr, w.data);
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b0;
    bus.wb_we = 0; bus.wb_addr = '0; bus.wb_data = '0;
    bus.mc_valid = 0; bus.mc_addr = '0; bus.mc_data = '0;
    bus.rd_addr1 = '0; bus.rd_addr2 = '0;

    // Reset.
    repeat (3) step(0, 1, 5, 32'h1, 1, 6, 32'h2, 6, 5);
    // WB only.
    step(1, 1, 5, 32'hA5A5A5A5, 0, 0, 0, 5, 0);
    // MC drain with pending hit until the pop edge.
    step(1, 0, 0, 0, 1, 7, 32'h1234, 7, 0);
    step(1, 0, 0, 0, 0, 0, 0, 7, 7);
    step(1, 0, 0, 0, 0, 0, 0, 7, 7);
    // Starvation: WB wins three times, head forced in, then held WB lands.
    step(1, 1, 10, 32'hA0, 1, 3, 32'h33, 3, 0);
    for (int i = 0; i < 5; i++) step(1, 1, 5'(11 + i), 32'(32'hB0 + i), 0, 0, 0, 3, 0);
    // Collision on r9.
    step(1, 0, 0, 0, 1, 9, 32'h99, 0, 0);
    step(1, 1, 9, 32'hB9, 0, 0, 0, 9, 0);
    step(1, 1, 9, 32'hB9, 0, 0, 0, 9, 0);
    // Fill to full with WB busy; forced pop with mc_valid must not push.
    for (int i = 0; i < 4; i++) step(1, 1, 5'(20 + i), 32'(i), 1, 5'(1 + i), 32'(32'h10 + i), 1, 4);
    step(1, 1, 25, 32'h25, 1, 8, 32'h88, 8, 0);
    // Ten push/pop cycles through the wrap.
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 1, 5'(10 + i), 32'(32'hC0 + i), 5'(10 + i), 5'(9 + i));
    repeat (4) step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    // Address 0: consumed without a write, never a hit.
    step(1, 0, 0, 0, 1, 0, 32'hFFFF, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    // Reset with three queued entries discards them.
    for (int i = 0; i < 3; i++) step(1, 1, 5'(26 + i), 32'(i), 1, 5'(3 + i), 32'(32'hD0 + i), 3, 5);
    step(0, 0, 0, 0, 1, 6, 32'h66, 3, 5);
    step(1, 0, 0, 0, 0, 0, 0, 3, 5);
    step(1, 0, 0, 0, 0, 0, 0, 3, 5);

    // Randomized traffic over a small address range for frequent collisions.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) != 0),
           ($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom,
           ($urandom_range(0, 9) < 5), 5'($urandom_range(0, 7)), $urandom,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end

    @(negedge clk);
    #1;
    tests++;
    if (sq.size() != 0 || wq.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d status and %0d writes left, exp 0 and 0", sq.size(), wq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
